// File: rtl/seq_div4_restoring.sv
// Multi-cycle unsigned restoring divider: one shift/trial-subtract/restore step per clock.
// start/busy/done handshake. A zero divisor finishes in one cycle with the div_by_zero flag set.
module seq_div4_restoring #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic             accept;

  // The restored partial remainder is always below D, so its top bit is zero between steps.
  // Only the shifted value and the trial difference need WIDTH+1 bits.
  assign r_shift = {r_reg, q_reg[WIDTH-1]};
  assign trial   = r_shift - {1'b0, d_reg};
  assign r_step  = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_step  = {q_reg[WIDTH-2:0], ~trial[WIDTH]};
  assign accept  = start && (state_reg != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      r_reg     <= r_next;
      cnt_reg   <= cnt_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    d_next     = d_reg;
    r_next     = r_reg;
    cnt_next   = cnt_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;

    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (accept) begin
          q_next   = dividend;
          d_next   = divisor;
          r_next   = '0;
          cnt_next = '0;
          if (divisor == '0) begin
            state_next = DONE;
            quo_next   = '1;
            rem_next   = dividend;
            dbz_next   = 1'b1;
          end else begin
            state_next = RUN;
            dbz_next   = 1'b0;
          end
        end
      end
      RUN: begin
        q_next   = q_step;
        r_next   = r_step;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = DONE;
          quo_next   = q_step;
          rem_next   = r_step;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state_reg == RUN);
  assign done        = (state_reg == DONE);
  assign quotient    = quo_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_div4_restoring.sv
// Scoreboard bench for seq_div4_restoring: the driver pushes the arithmetic result and the expected
// done cycle for every accepted start, and the monitor compares each done pulse against the queue.
module tb_seq_div4_restoring;
  localparam int W   = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_div4_restoring #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    int exp_cyc;
    int q;
    int r;
    bit dbz;
    bit nz;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   last_q = 0;
  int   last_r = 0;
  int   last_dbz = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones quotient and the dividend back.
  task automatic issue(input int a, input int b, output int lat);
    exp_t e;
    lat       = (b == 0) ? 1 : W + 1;
    e.exp_cyc = cyc + lat;
    e.nz      = (b != 0);
    e.dbz     = (b == 0);
    e.q       = (b == 0) ? MAXV : a / b;
    e.r       = (b == 0) ? a : a % b;
    sb.push_back(e);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom_range(0, MAXV));
    divisor  = W'($urandom_range(0, MAXV));
  endtask

  // Returns in the done cycle; optionally pulses a start that must be ignored in the 2nd busy cycle.
  task automatic finish_op(input int lat, input bit spur, input int sa, input int sd);
    if (spur && lat > 3) begin
      @(posedge clk); #1;
      start    = 1'b1;
      dividend = W'(sa);
      divisor  = W'(sd);
      @(posedge clk); #1;
      start    = 1'b0;
      repeat (lat - 3) begin @(posedge clk); #1; end
    end else begin
      repeat (lat - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_quotient"}, int'(quotient), 0);
    chk({tag, "_remainder"}, int'(remainder), 0);
    chk({tag, "_dbz"}, int'(div_by_zero), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_busy;
      exp_busy = (sb.size() > 0) && sb[0].nz &&
                 (cyc >= sb[0].exp_cyc - W) && (cyc < sb[0].exp_cyc);
      chk("busy", int'(busy), int'(exp_busy));
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("done at cycle %0d: quotient=%0d remainder=%0d dbz=%0d (model %0d/%0d/%0d)",
                   cyc, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
          chk("done_cycle", cyc, e.exp_cyc);
          chk("quotient", int'(quotient), e.q);
          chk("remainder", int'(remainder), e.r);
          chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
          last_q   = e.q;
          last_r   = e.r;
          last_dbz = int'(e.dbz);
        end
      end else if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
        chk("done_timeout", cyc, sb[0].exp_cyc);
        void'(sb.pop_front());
      end else if (sb.size() == 0) begin
        chk("hold_quotient", int'(quotient), last_q);
        chk("hold_remainder", int'(remainder), last_r);
        chk("hold_dbz", int'(div_by_zero), last_dbz);
      end
    end
  end

  initial begin
    int da[6] = '{13, 15, 7, 0, 15, 9};
    int dd[6] = '{3, 1, 9, 5, 15, 0};
    int lat;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 6; i++) begin
      issue(da[i], dd[i], lat);
      finish_op(lat, 1'b0, 0, 0);
      idle(1);
    end

    // start during busy must not disturb 13/3
    issue(13, 3, lat);
    finish_op(lat, 1'b1, 2, 1);
    idle(1);

    // abort in the 3rd busy cycle, then a clean 10/4
    issue(13, 3, lat);
    idle(2);
    rst_n = 1'b0;
    #1;
    check_reset("abort");
    sb.delete();
    last_q = 0; last_r = 0; last_dbz = 0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    issue(10, 4, lat);
    finish_op(lat, 1'b0, 0, 0);
    idle(1);

    // back-to-back: zero-divisor start during the done cycle of 12/5
    issue(12, 5, lat);
    finish_op(lat, 1'b0, 0, 0);
    issue(6, 0, lat);
    finish_op(lat, 1'b0, 0, 0);
    idle(2);

    for (int i = 0; i < 60; i++) begin
      int a, b, mode;
      a    = $urandom_range(0, MAXV);
      b    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MAXV);
      mode = $urandom_range(0, 2);
      issue(a, b, lat);
      finish_op(lat, mode == 2, $urandom_range(0, MAXV), $urandom_range(0, MAXV));
      if (mode != 1) idle($urandom_range(1, 3));
    end

    idle(3);
    chk("drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
